// File: rtl/cpu_pkg.sv
// Shared definitions for the single-cycle core front end.
// The decoder uses the same PCS_* constants that the fetch stage uses.
package cpu_pkg;

    localparam int WORD_W = 32;

    // pcsource encodings produced by the main control decoder
    localparam logic [1:0] PCS_SEQ = 2'b00;  // pc + 4
    localparam logic [1:0] PCS_BR  = 2'b01;  // taken branch
    localparam logic [1:0] PCS_REG = 2'b10;  // jr / jalr
    localparam logic [1:0] PCS_JMP = 2'b11;  // j / jal

    typedef enum logic [1:0] {
        ST_FETCH = 2'b00,
        ST_EXEC  = 2'b01,
        ST_HALT  = 2'b10
    } fetch_state_e;

endpackage

// File: rtl/ifetch_unit_if.sv
// Instruction memory read channel (req/ack handshake).
//   imem_req   : read request, held until ack
//   imem_addr  : word-aligned fetch address
//   imem_ack   : imem_rdata valid this cycle
//   imem_rdata : instruction word
// master = fetch stage, slave = instruction memory.
interface ifetch_unit_if;
    import cpu_pkg::*;

    logic              imem_req;
    logic [WORD_W-1:0] imem_addr;
    logic              imem_ack;
    logic [WORD_W-1:0] imem_rdata;

    modport master (output imem_req, output imem_addr,
                    input  imem_ack, input  imem_rdata);
    modport slave  (input  imem_req, input  imem_addr,
                    output imem_ack, output imem_rdata);
endinterface

// File: rtl/ifetch_unit_npc_calc.sv
// Next-PC selection, purely combinational.
//   pc, inst, pcsource, ra_data : current PC, executing instruction,
//                                 decoder select, rs value
//   npc        : next PC (all arithmetic mod 2^32)
//   misaligned : register target not word aligned
module npc_calc
    import cpu_pkg::*;
(
    input  logic [WORD_W-1:0] pc,
    input  logic [WORD_W-1:0] inst,
    input  logic [1:0]        pcsource,
    input  logic [WORD_W-1:0] ra_data,
    output logic [WORD_W-1:0] npc,
    output logic              misaligned
);

    logic [WORD_W-1:0] seq_pc;
    logic [WORD_W-1:0] br_off;
    logic              unused_opcode;

    assign seq_pc        = pc + 32'd4;
    assign br_off        = {{14{inst[15]}}, inst[15:0], 2'b00};
    assign unused_opcode = ^inst[31:26];

    always_comb begin
        npc = seq_pc;
        case (pcsource)
            PCS_SEQ: npc = seq_pc;
            PCS_BR:  npc = seq_pc + br_off;
            PCS_REG: npc = ra_data;
            PCS_JMP: npc = {seq_pc[31:28], inst[25:0], 2'b00};
            default: npc = seq_pc;
        endcase
    end

    // Branch and jump targets are word aligned by construction; only jr/jalr can go wrong.
    assign misaligned = (pcsource == PCS_REG) && (ra_data[1:0] != 2'b00);

endmodule

// File: rtl/ifetch_unit.sv
// PC and instruction-fetch stage for the single-cycle core.
//   clk, resetn          : clock, synchronous active-low reset
//   imem (master)        : instruction memory req/ack read channel
//   inst, inst_valid     : latched instruction and its executing flag
//   pc, pc_plus4         : current PC and its link value
//   ex_done, pcsource,
//   ra_data              : datapath completion and next-PC select
//   fetch_err            : sticky fault (fetch timeout / misaligned jr target)
//   retired              : completed-instruction count
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_FETCH | requesting imem at pc, waiting for ack
// ST_EXEC  | inst valid, waiting for ex_done
// ST_HALT  | faulted, outputs idle until reset
module ifetch_unit
    import cpu_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC = 32'h0000_0000,
    parameter int                MAX_WAIT = 16
)(
    input  logic              clk,
    input  logic              resetn,
    ifetch_unit_if.master     imem,
    output logic [WORD_W-1:0] inst,
    output logic [WORD_W-1:0] pc,
    output logic [WORD_W-1:0] pc_plus4,
    output logic              inst_valid,
    input  logic              ex_done,
    input  logic [1:0]        pcsource,
    input  logic [WORD_W-1:0] ra_data,
    output logic              fetch_err,
    output logic [WORD_W-1:0] retired
);

    localparam logic [15:0] WAIT_LAST = 16'(MAX_WAIT - 1);

    fetch_state_e      state_q, state_d;
    logic [WORD_W-1:0] pc_q, pc_d;
    logic [WORD_W-1:0] inst_q, inst_d;
    logic [WORD_W-1:0] retired_q, retired_d;
    logic              fetch_err_q, fetch_err_d;
    logic [15:0]       wait_q, wait_d;

    logic [WORD_W-1:0] npc;
    logic              misaligned;

    npc_calc u_npc_calc (
        .pc         (pc_q),
        .inst       (inst_q),
        .pcsource   (pcsource),
        .ra_data    (ra_data),
        .npc        (npc),
        .misaligned (misaligned)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= ST_FETCH;
            pc_q        <= RESET_PC;
            inst_q      <= '0;
            retired_q   <= '0;
            fetch_err_q <= 1'b0;
            wait_q      <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            inst_q      <= inst_d;
            retired_q   <= retired_d;
            fetch_err_q <= fetch_err_d;
            wait_q      <= wait_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        inst_d      = inst_q;
        retired_d   = retired_q;
        fetch_err_d = fetch_err_q;
        wait_d      = wait_q;
        case (state_q)
            ST_FETCH: begin
                // Ack on the final wait cycle still wins over the timeout.
                if (imem.imem_ack) begin
                    inst_d  = imem.imem_rdata;
                    wait_d  = '0;
                    state_d = ST_EXEC;
                end else if ((MAX_WAIT != 0) && (wait_q == WAIT_LAST)) begin
                    fetch_err_d = 1'b1;
                    state_d     = ST_HALT;
                end else begin
                    wait_d = wait_q + 16'd1;
                end
            end
            ST_EXEC: begin
                if (ex_done) begin
                    if (misaligned) begin
                        fetch_err_d = 1'b1;
                        state_d     = ST_HALT;
                    end else begin
                        pc_d      = npc;
                        retired_d = retired_q + 32'd1;
                        wait_d    = '0;
                        state_d   = ST_FETCH;
                    end
                end
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_FETCH;
        endcase
    end

    assign imem.imem_req  = (state_q == ST_FETCH);
    assign imem.imem_addr = pc_q;
    assign inst_valid     = (state_q == ST_EXEC);
    assign inst           = inst_q;
    assign pc             = pc_q;
    assign pc_plus4       = pc_q + 32'd4;
    assign fetch_err      = fetch_err_q;
    assign retired        = retired_q;

endmodule

// File: tb/tb_ifetch_unit.sv
module tb_ifetch_unit;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] inst, pc, pc_plus4, retired, ra_data;
    logic        inst_valid, ex_done, fetch_err;
    logic [1:0]  pcsource;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_ret = 32'd0;

    ifetch_unit_if imem_if ();

    ifetch_unit #(.RESET_PC(32'h0000_0000), .MAX_WAIT(4)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .imem       (imem_if),
        .inst       (inst),
        .pc         (pc),
        .pc_plus4   (pc_plus4),
        .inst_valid (inst_valid),
        .ex_done    (ex_done),
        .pcsource   (pcsource),
        .ra_data    (ra_data),
        .fetch_err  (fetch_err),
        .retired    (retired)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Stimulus helpers: both start and end on a falling edge.
    task automatic fetch(input logic [31:0] word);
        imem_if.imem_ack   = 1'b1;
        imem_if.imem_rdata = word;
        @(negedge clk);
        imem_if.imem_ack   = 1'b0;
    endtask

    task automatic exec(input logic [1:0] pcs, input logic [31:0] ra);
        ex_done  = 1'b1;
        pcsource = pcs;
        ra_data  = ra;
        @(negedge clk);
        ex_done  = 1'b0;
        if (!(pcs == PCS_REG && ra[1:0] != 2'b00)) exp_ret = exp_ret + 32'd1;
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        ex_done = 1'b0; pcsource = 2'b00; ra_data = '0;
        imem_if.imem_ack = 1'b0; imem_if.imem_rdata = '0;
        @(negedge clk); @(negedge clk);
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp %h", pc, 32'h0); end
        checks++; if (inst !== 32'h0 || inst_valid !== 1'b0) begin errors++; $display("FAIL reset_inst got %h/%b exp 0/0", inst, inst_valid); end
        checks++; if (fetch_err !== 1'b0 || retired !== 32'h0) begin errors++; $display("FAIL reset_err_ret got %b/%h exp 0/0", fetch_err, retired); end
        checks++; if (imem_if.imem_req !== 1'b1 || imem_if.imem_addr !== 32'h0) begin errors++; $display("FAIL reset_req got %b/%h exp 1/0", imem_if.imem_req, imem_if.imem_addr); end
        resetn = 1'b1;
        fetch(32'h2008_0005);
        checks++; if (inst_valid !== 1'b1 || inst !== 32'h2008_0005) begin errors++; $display("FAIL zero_wait_inst got %b/%h exp 1/20080005", inst_valid, inst); end
        checks++; if (imem_if.imem_req !== 1'b0) begin errors++; $display("FAIL exec_req got %b exp 0", imem_if.imem_req); end
        exec(PCS_SEQ, 32'h0);
        checks++; if (pc !== 32'h4 || retired !== 32'd1) begin errors++; $display("FAIL seq_pc got %h/%0d exp 4/1", pc, retired); end
        checks++; if (inst_valid !== 1'b0 || imem_if.imem_req !== 1'b1) begin errors++; $display("FAIL seq_refetch got %b/%b exp 0/1", inst_valid, imem_if.imem_req); end
    endtask

    task automatic test_branch;
        fetch(32'h0);            exec(PCS_REG, 32'h0000_0010);
        fetch(32'h1000_FFFC);    exec(PCS_BR, 32'h0);
        checks++; if (pc !== 32'h0000_0004) begin errors++; $display("FAIL branch_back got %h exp 00000004", pc); end
        fetch(32'h0);            exec(PCS_REG, 32'h0000_0010);
        fetch(32'h1000_0003);    exec(PCS_BR, 32'h0);
        checks++; if (pc !== 32'h0000_0020) begin errors++; $display("FAIL branch_fwd got %h exp 00000020", pc); end
        checks++; if (retired !== exp_ret) begin errors++; $display("FAIL branch_retired got %0d exp %0d", retired, exp_ret); end
    endtask

    task automatic test_jump;
        fetch(32'h0);            exec(PCS_REG, 32'h4000_0100);
        fetch(32'h0800_0040);    exec(PCS_JMP, 32'h0);
        checks++; if (pc !== 32'h4000_0100) begin errors++; $display("FAIL jump got %h exp 40000100", pc); end
        fetch(32'h0);            exec(PCS_REG, 32'h0000_0200);
        checks++; if (pc !== 32'h0000_0200) begin errors++; $display("FAIL jr got %h exp 00000200", pc); end
    endtask

    task automatic test_spurious;
        ex_done = 1'b1; pcsource = PCS_REG; ra_data = 32'h0000_0123;
        @(negedge clk);
        ex_done = 1'b0;
        checks++; if (pc !== 32'h200 || imem_if.imem_req !== 1'b1 || inst_valid !== 1'b0) begin errors++; $display("FAIL exdone_in_fetch got pc %h req %b iv %b exp 200/1/0", pc, imem_if.imem_req, inst_valid); end
        fetch(32'hAAAA_0001);
        pcsource = PCS_SEQ;
        imem_if.imem_ack = 1'b1; imem_if.imem_rdata = 32'h5555_0002;
        @(negedge clk);
        imem_if.imem_ack = 1'b0;
        checks++; if (inst !== 32'hAAAA_0001 || inst_valid !== 1'b1 || pc !== 32'h200) begin errors++; $display("FAIL ack_in_exec got %h/%b/%h exp aaaa0001/1/200", inst, inst_valid, pc); end
        exec(PCS_SEQ, 32'h0);
        checks++; if (pc !== 32'h204 || retired !== exp_ret) begin errors++; $display("FAIL after_spurious got %h/%0d exp 204/%0d", pc, retired, exp_ret); end
    endtask

    task automatic test_wait_states;
        int bad = 0;
        imem_if.imem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (imem_if.imem_req !== 1'b1 || imem_if.imem_addr !== 32'h204) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL wait_addr_stable got %0d bad cycles exp 0", bad); end
        fetch(32'h1234_5678);
        checks++; if (inst_valid !== 1'b1 || fetch_err !== 1'b0 || inst !== 32'h1234_5678) begin errors++; $display("FAIL ack_last_wait got %b/%b/%h exp 1/0/12345678", inst_valid, fetch_err, inst); end
        exec(PCS_SEQ, 32'h0);
    endtask

    task automatic test_wrap;
        fetch(32'h0);   exec(PCS_REG, 32'hFFFF_FFFC);
        checks++; if (pc_plus4 !== 32'h0) begin errors++; $display("FAIL pc_plus4_wrap got %h exp 0", pc_plus4); end
        fetch(32'h0);   exec(PCS_SEQ, 32'h0);
        checks++; if (pc !== 32'h0 || fetch_err !== 1'b0) begin errors++; $display("FAIL wrap got %h/%b exp 0/0", pc, fetch_err); end
    endtask

    task automatic test_misaligned;
        fetch(32'h0);   exec(PCS_REG, 32'h0000_0100);
        fetch(32'h0);   exec(PCS_REG, 32'h0000_0202);
        checks++; if (fetch_err !== 1'b1 || pc !== 32'h100 || retired !== exp_ret) begin errors++; $display("FAIL misaligned got %b/%h/%0d exp 1/100/%0d", fetch_err, pc, retired, exp_ret); end
        imem_if.imem_ack = 1'b1;
        @(negedge clk); @(negedge clk);
        imem_if.imem_ack = 1'b0;
        checks++; if (imem_if.imem_req !== 1'b0 || inst_valid !== 1'b0 || pc !== 32'h100) begin errors++; $display("FAIL halt_idle got %b/%b/%h exp 0/0/100", imem_if.imem_req, inst_valid, pc); end
    endtask

    task automatic test_timeout;
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        exp_ret = 32'd0;
        checks++; if (fetch_err !== 1'b0 || imem_if.imem_req !== 1'b1) begin errors++; $display("FAIL reset_clears_err got %b/%b exp 0/1", fetch_err, imem_if.imem_req); end
        imem_if.imem_ack = 1'b0;
        @(negedge clk); @(negedge clk); @(negedge clk);
        checks++; if (fetch_err !== 1'b0 || imem_if.imem_req !== 1'b1) begin errors++; $display("FAIL timeout_early got %b/%b exp 0/1", fetch_err, imem_if.imem_req); end
        @(negedge clk);
        checks++; if (fetch_err !== 1'b1 || imem_if.imem_req !== 1'b0) begin errors++; $display("FAIL timeout got %b/%b exp 1/0", fetch_err, imem_if.imem_req); end
        imem_if.imem_ack = 1'b1;
        @(negedge clk);
        imem_if.imem_ack = 1'b0;
        checks++; if (imem_if.imem_req !== 1'b0 || inst_valid !== 1'b0) begin errors++; $display("FAIL timeout_sticky got %b/%b exp 0/0", imem_if.imem_req, inst_valid); end
    endtask

    task automatic test_reset_vs_exdone;
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        fetch(32'h0);  exec(PCS_SEQ, 32'h0);
        fetch(32'h0);
        resetn = 1'b0; ex_done = 1'b1; pcsource = PCS_SEQ;
        @(negedge clk);
        resetn = 1'b1; ex_done = 1'b0;
        checks++; if (pc !== 32'h0 || retired !== 32'h0 || inst_valid !== 1'b0) begin errors++; $display("FAIL reset_wins got %h/%0d/%b exp 0/0/0", pc, retired, inst_valid); end
        checks++; if (imem_if.imem_req !== 1'b1 || imem_if.imem_addr !== 32'h0) begin errors++; $display("FAIL reset_restart got %b/%h exp 1/0", imem_if.imem_req, imem_if.imem_addr); end
    endtask

    initial begin
        test_reset();
        test_branch();
        test_jump();
        test_spurious();
        test_wait_states();
        test_wrap();
        test_misaligned();
        test_timeout();
        test_reset_vs_exdone();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
